// File: rtl/sequence_generator_moore_pkg.sv
// rtl/sequence_generator_moore_pkg.sv - shared state encoding and default pattern for generator/detector
package sequence_generator_moore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         DEFAULT_PAT_W   = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_generator_moore_if.sv
// rtl/sequence_generator_moore_if.sv - request and serial-stream signals of the pattern generator
interface sequence_generator_moore_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_count;
    logic             sequence_out;
    logic             bit_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern_in, repeat_count,
        input  sequence_out, bit_valid, frame_start, busy, done
    );

    modport slave (
        input  start, abort, pattern_in, repeat_count,
        output sequence_out, bit_valid, frame_start, busy, done
    );
endinterface

// File: rtl/sequence_shift_reg.sv
// rtl/sequence_shift_reg.sv - PAT_W-bit load / rotate-left register with MSB tap
module sequence_shift_reg
    import sequence_generator_moore_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             rotate,
    input  logic [PAT_W-1:0] data_in,
    output logic             msb
);
    logic [PAT_W-1:0] data;

    // Rotation keeps the pattern intact so every repetition reuses it without reloading.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (load) begin
            data <= data_in;
        end else if (rotate) begin
            data <= {data[PAT_W-2:0], data[PAT_W-1]};
        end
    end

    assign msb = data[PAT_W-1];
endmodule

// File: rtl/sequence_generator_moore.sv
// rtl/sequence_generator_moore.sv - Moore FSM serial pattern transmitter with repeat and idle gaps
module sequence_generator_moore
    import sequence_generator_moore_pkg::*;
#(
    parameter int   PAT_W      = 4,
    parameter int   CNT_W      = 8,
    parameter int   GAP_LEN    = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    sequence_generator_moore_if.slave bus
);
    localparam int              BW        = $clog2(PAT_W);
    localparam logic [BW-1:0]   BIT_FIRST = BW'(PAT_W - 1);
    localparam int              GW        = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0]   GAP_LAST  = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

    state_t           state, state_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
    logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
    logic             load, rotate, msb;

    sequence_shift_reg #(.PAT_W(PAT_W)) u_shift (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .rotate  (rotate),
        .data_in (bus.pattern_in),
        .msb     (msb)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            rep_cnt <= rep_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rep_cnt_nxt = rep_cnt;
        gap_cnt_nxt = gap_cnt;
        load        = 1'b0;
        rotate      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    load        = 1'b1;
                    rep_cnt_nxt = bus.repeat_count;
                    bit_cnt_nxt = BIT_FIRST;
                    state_nxt   = (bus.repeat_count != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                rotate      = 1'b1;
                bit_cnt_nxt = bit_cnt - BW'(1);
                if (bit_cnt == '0) begin
                    rep_cnt_nxt = rep_cnt - CNT_W'(1);
                    bit_cnt_nxt = BIT_FIRST;
                    if (rep_cnt_nxt == '0) begin
                        state_nxt = ST_DONE;
                    end else if (GAP_LEN > 0) begin
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = GAP_LAST;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_SEND;
                end else begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        // Abort discards the frame from any active state and suppresses the done pulse.
        if (bus.abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
            rotate    = 1'b0;
        end
    end

    assign bus.sequence_out = (state == ST_SEND) ? msb : IDLE_LEVEL;
    assign bus.bit_valid    = (state == ST_SEND);
    assign bus.frame_start  = (state == ST_SEND) && (bit_cnt == BIT_FIRST);
    assign bus.busy         = (state == ST_SEND) || (state == ST_GAP);
    assign bus.done         = (state == ST_DONE);
endmodule
